spi_reg_master: RTL and testbench

SPI controller that drives the register-access command protocol from the host side: an 8-bit command byte, then one REG_W-bit data word for reads and writes. It runs in mode 0 (CPOL=0, CPHA=0). MOSI changes on falling SCLK and the target samples on rising SCLK. The block sits between an on-chip request/response interface and the chip pins (sclk, nss, mosi, miso), and talks to our SPI register slave.

---
 rtl/spi_reg_pkg.sv | 24 ++
 rtl/spi_reg_master_if.sv | 25 ++
 rtl/spi_sclk_timer.sv | 30 +++
 rtl/spi_reg_master.sv | 161 ++++++++++++++++
 tb/tb_spi_reg_master.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types for the SPI register-access master.
// Op codes, FSM states and the command width.
package spi_reg_pkg;

    localparam int CMD_W = 8;

    typedef enum logic [1:0] {
        OP_RD   = 2'b00,
        OP_WR   = 2'b10,
        OP_FAST = 2'b11
    } op_t;

    localparam logic [1:0] OP_RSV = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD,
        ST_GAP
    } state_t;

endpackage

// File: rtl/spi_reg_master_if.sv
// Request/response bundle between the host logic and the SPI master.
// master = host side, slave = the SPI master block.
interface spi_reg_master_if #(
    parameter int REG_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [5:0]       req_addr;
    logic [REG_W-1:0] req_wdata;
    logic             rsp_valid;
    logic             rsp_err;
    logic [7:0]       rsp_status;
    logic [REG_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_status, rsp_rdata
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_status, rsp_rdata
    );
endinterface

// File: rtl/spi_sclk_timer.sv
// Phase timer: reloadable down-counter with a one-cycle done pulse.
// A load of V gives done on the V+1-th cycle after the load edge.
module spi_sclk_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt;
    logic         run;

    // Count down while running; stop at zero unless reloaded.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (load) begin
            cnt <= load_val;
            run <= 1'b1;
        end else if (run) begin
            if (cnt == '0) run <= 1'b0;
            else           cnt <= cnt - 1'b1;
        end
    end

    assign done = run && (cnt == '0);
endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 master for the register command protocol.
// Frame: {op, addr} command byte, then one data word unless fastcmd.
module spi_reg_master
    import spi_reg_pkg::*;
#(
    parameter int REG_W   = 8,
    parameter int CLK_DIV = 4,
    parameter int GAP     = 4
) (
    input  logic            clk,
    input  logic            nrst,
    spi_reg_master_if.slave bus,
    output logic            busy,
    output logic            sclk,
    output logic            nss,
    output logic            mosi,
    input  logic            miso
);
    localparam int FW   = CMD_W + REG_W;
    localparam int TMAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
    localparam int TW   = $clog2(TMAX);
    localparam int BW   = $clog2(FW);

    state_t          state;
    logic [FW-1:0]   tx_sh;
    logic [FW-1:0]   rx_sh;
    logic [BW-1:0]   bcnt;
    logic            is_fast;
    logic            miso_q1;
    logic            miso_q2;
    logic            accept;
    logic            tmr_load;
    logic            tmr_done;
    logic [TW-1:0]   tmr_val;

    assign accept = bus.req_valid && bus.req_ready;

    // Every phase change restarts the timer; GAP has its own length.
    assign tmr_load = (state == ST_IDLE)
                    ? (accept && bus.req_op != OP_RSV)
                    : (tmr_done && state != ST_GAP);
    assign tmr_val  = (state == ST_HOLD) ? TW'(GAP - 1) : TW'(CLK_DIV - 1);

    spi_sclk_timer #(.W(TW)) u_tmr (
        .clk      (clk),
        .nrst     (nrst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Two-flop synchronizer for the asynchronous miso pin.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            miso_q1 <= 1'b0;
            miso_q2 <= 1'b0;
        end else begin
            miso_q1 <= miso;
            miso_q2 <= miso_q1;
        end
    end

    // Frame sequencer; all pin and response outputs are registered here.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state          <= ST_IDLE;
            tx_sh          <= '0;
            rx_sh          <= '0;
            bcnt           <= '0;
            is_fast        <= 1'b0;
            sclk           <= 1'b0;
            nss            <= 1'b1;
            mosi           <= 1'b0;
            busy           <= 1'b0;
            bus.req_ready  <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_err    <= 1'b0;
            bus.rsp_status <= '0;
            bus.rsp_rdata  <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (accept) begin
                        if (bus.req_op == OP_RSV) begin
                            bus.rsp_valid  <= 1'b1;
                            bus.rsp_err    <= 1'b1;
                            bus.rsp_status <= '0;
                            bus.rsp_rdata  <= '0;
                        end else begin
                            state         <= ST_SETUP;
                            bus.req_ready <= 1'b0;
                            busy          <= 1'b1;
                            nss           <= 1'b0;
                            mosi          <= bus.req_op[1];
                            // MSB goes straight to mosi; keep the rest.
                            tx_sh   <= {bus.req_op[0], bus.req_addr,
                                        bus.req_wdata, 1'b0};
                            is_fast <= (bus.req_op == OP_FAST);
                            bcnt    <= (bus.req_op == OP_FAST)
                                     ? BW'(CMD_W - 1) : BW'(FW - 1);
                        end
                    end
                end
                ST_SETUP: begin
                    if (tmr_done) begin
                        state <= ST_HIGH;
                        sclk  <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (tmr_done) begin
                        state <= ST_LOW;
                        sclk  <= 1'b0;
                        rx_sh <= {rx_sh[FW-2:0], miso_q2};
                        if (bcnt != '0) begin
                            mosi  <= tx_sh[FW-1];
                            tx_sh <= tx_sh << 1;
                        end
                    end
                end
                ST_LOW: begin
                    if (tmr_done) begin
                        if (bcnt == '0) begin
                            state <= ST_HOLD;
                        end else begin
                            state <= ST_HIGH;
                            sclk  <= 1'b1;
                            bcnt  <= bcnt - 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tmr_done) begin
                        state         <= ST_GAP;
                        nss           <= 1'b1;
                        mosi          <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        if (is_fast) begin
                            bus.rsp_status <= rx_sh[CMD_W-1:0];
                            bus.rsp_rdata  <= '0;
                        end else begin
                            bus.rsp_status <= rx_sh[FW-1:REG_W];
                            bus.rsp_rdata  <= rx_sh[REG_W-1:0];
                        end
                    end
                end
                ST_GAP: begin
                    if (tmr_done) begin
                        state         <= ST_IDLE;
                        busy          <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_reg_master.sv
// Self-checking bench for spi_reg_master with a behavioural SPI target.
// Target: status byte, 64 x 8-bit regs, write log, fastcmd log.
module tb_spi_reg_master;
    import spi_reg_pkg::*;

    localparam int REG_W   = 8;
    localparam int CLK_DIV = 4;
    localparam int GAP     = 4;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    logic busy, sclk, nss, mosi;
    logic miso = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spi_reg_master_if #(.REG_W(REG_W)) bus ();

    spi_reg_master #(
        .REG_W(REG_W), .CLK_DIV(CLK_DIV), .GAP(GAP)
    ) dut (
        .clk(clk), .nrst(nrst), .bus(bus), .busy(busy),
        .sclk(sclk), .nss(nss), .mosi(mosi), .miso(miso)
    );

    // Target memory model, written only by the stimulus process.
    logic [7:0] t_mem [64];
    logic [7:0] t_status;

    // Behavioural SPI target (mode 0).
    logic        p_nss = 1'b1;
    logic        p_sclk = 1'b0;
    int          s_bits = 0;
    logic [15:0] s_rx = '0;
    logic [15:0] s_tx = '0;
    logic [7:0]  cap_cmd = '0;
    logic [7:0]  cap_data = '0;
    int          sclk_rises = 0;
    int          frames = 0;
    int          f_bits = 0;
    int          w_cnt = 0;
    logic [5:0]  w_la [8];
    logic [7:0]  w_ld [8];
    int          f_cnt = 0;
    logic [5:0]  f_code = '0;

    always @(nss or sclk) begin
        if (nss !== p_nss) begin
            if (nss === 1'b0) begin
                s_bits = 0;
                s_rx   = '0;
                s_tx   = {t_status, 8'h00};
                miso   = s_tx[15];
            end else if (nss === 1'b1) begin
                frames++;
                f_bits = s_bits;
                if (s_bits == 16 && s_rx[15:14] == 2'b10) begin
                    w_la[w_cnt[2:0]] = s_rx[13:8];
                    w_ld[w_cnt[2:0]] = s_rx[7:0];
                    w_cnt++;
                end
                if (s_bits == 8 && s_rx[7:6] == 2'b11) begin
                    f_cnt++;
                    f_code = s_rx[5:0];
                end
            end
        end else if (nss === 1'b0 && sclk !== p_sclk) begin
            if (sclk === 1'b1) begin
                s_rx = {s_rx[14:0], mosi};
                s_bits++;
                sclk_rises++;
                if (s_bits == 8) begin
                    cap_cmd = s_rx[7:0];
                    if (s_rx[7:6] == 2'b00) s_tx[7:0] = t_mem[s_rx[5:0]];
                end
                if (s_bits == 16) cap_data = s_rx[7:0];
            end else if (sclk === 1'b0 && s_bits < 16) begin
                miso = s_tx[4'(15 - s_bits)];
            end
        end
        p_nss  = nss;
        p_sclk = sclk;
    end

    // Cycle counter and negedge monitors.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         rsp_cnt = 0;
    int         rsp_cyc [4];
    logic [7:0] rsp_st [4];
    logic [7:0] rsp_rd [4];
    logic       rsp_er [4];
    int         hi_run = 0;
    int         lo_run = 0;
    int         last_hi = 0;
    int         last_lo = 0;
    int         lo_total = 0;

    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            rsp_cyc[rsp_cnt[1:0]] = cyc;
            rsp_st[rsp_cnt[1:0]]  = bus.rsp_status;
            rsp_rd[rsp_cnt[1:0]]  = bus.rsp_rdata;
            rsp_er[rsp_cnt[1:0]]  = bus.rsp_err;
            rsp_cnt++;
        end
        if (nss === 1'b0) begin
            lo_total++;
            lo_run++;
            if (hi_run != 0) begin
                last_hi = hi_run;
                hi_run  = 0;
            end
        end else begin
            hi_run++;
            if (lo_run != 0) begin
                last_lo = lo_run;
                lo_run  = 0;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [5:0] a,
                         input logic [7:0] d, output int acc);
        bit ok;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_wdata = d;
        ok  = 1'b0;
        acc = 0;
        for (int i = 0; i < 400; i++) begin
            if (bus.req_ready === 1'b1) begin
                ok  = 1'b1;
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL accept: req_ready=%b required 1", bus.req_ready);
        end
    endtask

    task automatic wait_rsp(input int target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (rsp_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL rsp_timeout: got %0d responses required %0d",
                     rsp_cnt, target);
        end
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        obs = {sclk, nss, mosi, bus.req_ready, bus.rsp_valid,
               bus.rsp_err, busy};
        n_cmp++;
        if (obs !== 7'b0100000) begin
            n_bad++;
            $display("FAIL reset_pins: got %b required %b", obs, 7'b0100000);
        end
        n_cmp++;
        if ({bus.rsp_status, bus.rsp_rdata} !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_rsp: got %h required 0000",
                     {bus.rsp_status, bus.rsp_rdata});
        end
        @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset: ready=%b busy=%b required 1 0",
                     bus.req_ready, busy);
        end
    endtask

    // One full transaction checked against the target model.
    task automatic check_txn(input string tag, input logic [1:0] op,
                             input logic [5:0] a, input logic [7:0] d);
        int acc, n0, w0, f0, r0, nb, k;
        logic [7:0] e_rd;
        nb   = (op == OP_FAST) ? 8 : 16;
        e_rd = (op == OP_RD) ? t_mem[a] : 8'h00;
        n0 = rsp_cnt;
        w0 = w_cnt;
        f0 = f_cnt;
        r0 = sclk_rises;
        issue(op, a, d, acc);
        wait_rsp(n0 + 1);
        k = n0 % 4;
        n_cmp++;
        if (rsp_st[k] !== t_status || rsp_rd[k] !== e_rd ||
            rsp_er[k] !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_rsp: got st=%h rd=%h err=%b required %h %h 0",
                     tag, rsp_st[k], rsp_rd[k], rsp_er[k], t_status, e_rd);
        end
        n_cmp++;
        if (rsp_cyc[k] - acc !== 1 + CLK_DIV * (2 * nb + 2)) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d required %0d", tag,
                     rsp_cyc[k] - acc, 1 + CLK_DIV * (2 * nb + 2));
        end
        n_cmp++;
        if (last_lo !== CLK_DIV * (2 * nb + 2)) begin
            n_bad++;
            $display("FAIL %s_nss_low: got %0d required %0d", tag,
                     last_lo, CLK_DIV * (2 * nb + 2));
        end
        n_cmp++;
        if (sclk_rises - r0 !== nb || cap_cmd !== {op, a}) begin
            n_bad++;
            $display("FAIL %s_cmd: got pulses=%0d cmd=%h required %0d %h",
                     tag, sclk_rises - r0, cap_cmd, nb, {op, a});
        end
        if (nb == 16) begin
            n_cmp++;
            if (cap_data !== d) begin
                n_bad++;
                $display("FAIL %s_mosi_data: got %h required %h",
                         tag, cap_data, d);
            end
        end
        if (op == OP_WR) begin
            n_cmp++;
            if (w_cnt !== w0 + 1 || w_la[w0[2:0]] !== a ||
                w_ld[w0[2:0]] !== d) begin
                n_bad++;
                $display("FAIL %s_write: got n=%0d a=%h d=%h required %0d %h %h",
                         tag, w_cnt - w0, w_la[w0[2:0]], w_ld[w0[2:0]],
                         1, a, d);
            end
            t_mem[a] = d;
        end
        if (op == OP_FAST) begin
            n_cmp++;
            if (f_cnt !== f0 + 1 || f_code !== a) begin
                n_bad++;
                $display("FAIL %s_fast: got n=%0d code=%h required 1 %h",
                         tag, f_cnt - f0, f_code, a);
            end
        end
    endtask

    task automatic test_read();
        t_mem[5] = 8'hA7;
        t_status = 8'h3C;
        check_txn("read", OP_RD, 6'd5, 8'h00);
    endtask

    task automatic test_write();
        t_status = 8'h00;
        check_txn("write", OP_WR, 6'd2, 8'h5A);
    endtask

    task automatic test_fast();
        t_status = 8'h96;
        check_txn("fast", OP_FAST, 6'h15, 8'h00);
    endtask

    task automatic test_reserved();
        int acc, n0, fr0, lo0;
        n0  = rsp_cnt;
        fr0 = frames;
        lo0 = lo_total;
        issue(OP_RSV, 6'($urandom), 8'($urandom), acc);
        wait_rsp(n0 + 1);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (rsp_er[n0 % 4] !== 1'b1 || rsp_cyc[n0 % 4] - acc !== 1) begin
            n_bad++;
            $display("FAIL rsv_rsp: got err=%b lat=%0d required 1 1",
                     rsp_er[n0 % 4], rsp_cyc[n0 % 4] - acc);
        end
        n_cmp++;
        if ({rsp_st[n0 % 4], rsp_rd[n0 % 4]} !== 16'h0000) begin
            n_bad++;
            $display("FAIL rsv_data: got %h required 0000",
                     {rsp_st[n0 % 4], rsp_rd[n0 % 4]});
        end
        n_cmp++;
        if (frames !== fr0 || lo_total !== lo0) begin
            n_bad++;
            $display("FAIL rsv_nss: got frames=%0d low=%0d required 0 0",
                     frames - fr0, lo_total - lo0);
        end
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, n0, w0;
        bit ok;
        logic [5:0] a1, a2;
        logic [7:0] d1, d2;
        a1 = 6'($urandom);
        a2 = a1 ^ 6'h21;
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        n0 = rsp_cnt;
        w0 = w_cnt;
        acc1 = 0;
        acc2 = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_WR;
        bus.req_addr  = a1;
        bus.req_wdata = d1;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.req_ready === 1'b1) begin
                ok = 1'b1;
                acc1 = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.req_addr  = a2;
        bus.req_wdata = d2;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 400; i++) begin
                if (bus.req_ready === 1'b1) begin
                    ok = 1'b1;
                    acc2 = cyc;
                    break;
                end
                @(negedge clk);
            end
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL b2b_accept: req_ready=%b required 1", bus.req_ready);
        end
        wait_rsp(n0 + 2);
        n_cmp++;
        if (acc2 - rsp_cyc[n0 % 4] !== GAP) begin
            n_bad++;
            $display("FAIL b2b_turnaround: got %0d required %0d",
                     acc2 - rsp_cyc[n0 % 4], GAP);
        end
        // GAP state cycles plus the idle cycle that accepts the next request.
        n_cmp++;
        if (last_hi !== GAP + 1) begin
            n_bad++;
            $display("FAIL b2b_nss_high: got %0d required %0d",
                     last_hi, GAP + 1);
        end
        n_cmp++;
        if (w_cnt !== w0 + 2 || w_la[w0[2:0]] !== a1 ||
            w_ld[w0[2:0]] !== d1 || w_la[3'(w0 + 1)] !== a2 ||
            w_ld[3'(w0 + 1)] !== d2) begin
            n_bad++;
            $display("FAIL b2b_writes: got n=%0d %h:%h %h:%h required 2 %h:%h %h:%h",
                     w_cnt - w0, w_la[w0[2:0]], w_ld[w0[2:0]],
                     w_la[3'(w0 + 1)], w_ld[3'(w0 + 1)], a1, d1, a2, d2);
        end
        t_mem[a1] = d1;
        t_mem[a2] = d2;
    endtask

    task automatic test_reset_mid_frame();
        int acc, n0, w0;
        bit ok;
        n0 = rsp_cnt;
        w0 = w_cnt;
        issue(OP_WR, 6'd9, 8'hC3, acc);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (s_bits == 4 && nss === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL mid_reach_bit4: got bits=%0d required 4", s_bits);
        end
        #2;
        nrst = 1'b0;
        #1;
        n_cmp++;
        if (nss !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_pins: got nss=%b sclk=%b busy=%b required 1 0 0",
                     nss, sclk, busy);
        end
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (GAP + 4) @(negedge clk);
        n_cmp++;
        if (rsp_cnt !== n0 || w_cnt !== w0) begin
            n_bad++;
            $display("FAIL mid_no_rsp: got rsp=%0d writes=%0d required 0 0",
                     rsp_cnt - n0, w_cnt - w0);
        end
        t_status = 8'($urandom);
        check_txn("after_reset", OP_RD, 6'd9, 8'h00);
    endtask

    task automatic test_random();
        logic [1:0] op;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 2))
                0:       op = OP_RD;
                1:       op = OP_WR;
                default: op = OP_FAST;
            endcase
            t_status = 8'($urandom);
            check_txn("rand", op, 6'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        t_status      = 8'h00;
        for (int i = 0; i < 64; i++) t_mem[i] = 8'($urandom);
        test_reset();
        test_read();
        test_write();
        test_fast();
        test_reserved();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
